// File: rtl/adder_share_arb.sv
// Round-robin sequencer that shares one registered adder among N_REQ requesters.
// One operation in flight: IDLE -> ISSUE -> WAIT (ADD_LAT cycles) -> RESP -> IDLE.
module adder_share_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*WIDTH-1:0] Req_A,
    input  logic [N_REQ*WIDTH-1:0] Req_B,
    output logic [N_REQ-1:0]       Gnt,
    output logic [N_REQ-1:0]       Rsp_Valid,
    output logic [WIDTH-1:0]       Rsp_Sum,
    output logic                   Rsp_Ovf,
    output logic                   Busy,
    output logic [WIDTH-1:0]       Add_A,
    output logic [WIDTH-1:0]       Add_B,
    output logic                   Add_En,
    input  logic [WIDTH-1:0]       Add_Sum,
    input  logic                   Add_Ovf
);

    localparam int NR = int'(N_REQ);
    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q;
    logic [PW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] win_q;
    logic [N_REQ-1:0] gnt_q;
    logic [N_REQ-1:0] rsp_valid_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_ovf_q;
    logic             busy_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic             add_en_q;

    logic             win_vld;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    ptr_d;

    // First set request at or above the pointer, wrapping to the bottom.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NR; k++) begin
            idx = (int'(ptr_q) + k) % NR;
            if (!win_vld && Req[idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(idx);
            end
        end
        ptr_d = (int'(win_idx) == NR - 1) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            cnt_q       <= '0;
            win_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_en_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        add_a_q  <= Req_A[int'(win_idx)*WIDTH +: WIDTH];
                        add_b_q  <= Req_B[int'(win_idx)*WIDTH +: WIDTH];
                        add_en_q <= 1'b1;
                        gnt_q    <= N_REQ'(1) << win_idx;
                        win_q    <= N_REQ'(1) << win_idx;
                        ptr_q    <= ptr_d;
                        busy_q   <= 1'b1;
                        state_q  <= StIssue;
                    end
                end
                StIssue: begin
                    add_en_q <= 1'b0;
                    gnt_q    <= '0;
                    cnt_q    <= CW'(ADD_LAT - 1);
                    state_q  <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        rsp_sum_q   <= Add_Sum;
                        rsp_ovf_q   <= Add_Ovf;
                        rsp_valid_q <= win_q;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Gnt       = gnt_q;
    assign Rsp_Valid = rsp_valid_q;
    assign Rsp_Sum   = rsp_sum_q;
    assign Rsp_Ovf   = rsp_ovf_q;
    assign Busy      = busy_q;
    assign Add_A     = add_a_q;
    assign Add_B     = add_b_q;
    assign Add_En    = add_en_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: vector table, directed corner sequences, random ops vs. a
// transaction-level round-robin model. Two DUTs: ADD_LAT=1 and ADD_LAT=3.
module tb_adder_share_arb;

    logic        Clk;
    logic        Rst;
    logic [3:0]  req, req3;
    logic [15:0] req_a, req_b, req_a3, req_b3;
    logic [3:0]  gnt, rsp_valid, gnt3, rsp_valid3;
    logic [3:0]  rsp_sum, rsp_sum3, add_a, add_b, add_a3, add_b3, add_sum, add_sum3;
    logic        rsp_ovf, busy, add_en, add_ovf, rsp_ovf3, busy3, add_en3, add_ovf3;

    int n_chk = 0;
    int n_pass = 0;

    adder_share_arb #(.N_REQ(4), .WIDTH(4), .ADD_LAT(1)) u_dut (
        .Clk(Clk), .Rst(Rst), .Req(req), .Req_A(req_a), .Req_B(req_b),
        .Gnt(gnt), .Rsp_Valid(rsp_valid), .Rsp_Sum(rsp_sum), .Rsp_Ovf(rsp_ovf),
        .Busy(busy), .Add_A(add_a), .Add_B(add_b), .Add_En(add_en),
        .Add_Sum(add_sum), .Add_Ovf(add_ovf)
    );

    adder_share_arb #(.N_REQ(4), .WIDTH(4), .ADD_LAT(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst), .Req(req3), .Req_A(req_a3), .Req_B(req_b3),
        .Gnt(gnt3), .Rsp_Valid(rsp_valid3), .Rsp_Sum(rsp_sum3), .Rsp_Ovf(rsp_ovf3),
        .Busy(busy3), .Add_A(add_a3), .Add_B(add_b3), .Add_En(add_en3),
        .Add_Sum(add_sum3), .Add_Ovf(add_ovf3)
    );

    // Adder models: result usable ADD_LAT edges after the enable edge, junk otherwise.
    logic [4:0] pipe1;
    logic [4:0] pipe3 [3];
    always @(posedge Clk) begin
        pipe1    <= add_en ? ({1'b0, add_a} + {1'b0, add_b}) : 5'($urandom);
        pipe3[0] <= add_en3 ? ({1'b0, add_a3} + {1'b0, add_b3}) : 5'($urandom);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign {add_ovf, add_sum}   = pipe1;
    assign {add_ovf3, add_sum3} = pipe3[2];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One op on the ADD_LAT=1 DUT, starting and ending at a negedge with the DUT idle.
    task automatic run_op(input logic [3:0] r, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] eg, input logic [3:0] es, input logic eo,
                          input bit scr);
        int wa, wb;
        wa = 0;
        wb = 0;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                wa = int'(a[i*4 +: 4]);
                wb = int'(b[i*4 +: 4]);
            end
        end
        req   = r;
        req_a = a;
        req_b = b;
        @(negedge Clk);
        chk("gnt", int'(gnt), int'(eg));
        chk("add_en_issue", int'(add_en), int'(eg != 0));
        chk("busy_issue", int'(busy), int'(eg != 0));
        if (eg != 0) begin
            chk("add_a", int'(add_a), wa);
            chk("add_b", int'(add_b), wb);
            if (scr) begin
                req   = 4'($urandom);
                req_a = 16'($urandom);
                req_b = 16'($urandom);
            end
            @(negedge Clk);
            chk("gnt_wait", int'(gnt), 0);
            chk("add_en_wait", int'(add_en), 0);
            chk("rsp_valid_wait", int'(rsp_valid), 0);
            chk("busy_wait", int'(busy), 1);
            @(negedge Clk);
            chk("rsp_valid", int'(rsp_valid), int'(eg));
            chk("rsp_sum", int'(rsp_sum), int'(es));
            chk("rsp_ovf", int'(rsp_ovf), int'(eo));
            if (scr) req = 4'($urandom);
            @(negedge Clk);
            chk("rsp_valid_end", int'(rsp_valid), 0);
            chk("busy_end", int'(busy), 0);
            chk("rsp_sum_hold", int'(rsp_sum), int'(es));
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  gnt;
        logic [3:0]  sum;
        logic        ovf;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int ptr;
        logic [3:0]  r;
        logic [15:0] a, b;
        logic [3:0]  eg;
        logic [4:0]  s;

        // Pointer evolves across rows: 0 -> 1 -> 3 -> 3 -> 1 -> 0 -> 2.
        tbl[0] = '{4'b0001, 16'h0003, 16'h0004, 4'b0001, 4'd7,  1'b0};
        tbl[1] = '{4'b0100, 16'h0900, 16'h0800, 4'b0100, 4'd1,  1'b1};
        tbl[2] = '{4'b0100, 16'h0F00, 16'h0100, 4'b0100, 4'd0,  1'b1};
        tbl[3] = '{4'b0011, 16'h0065, 16'h0025, 4'b0001, 4'd10, 1'b0};
        tbl[4] = '{4'b1001, 16'h7001, 16'h7001, 4'b1000, 4'd14, 1'b0};
        tbl[5] = '{4'b1010, 16'h00C0, 16'h00C0, 4'b0010, 4'd8,  1'b1};

        Rst = 1'b1;
        req = '0; req_a = '0; req_b = '0;
        req3 = '0; req_a3 = '0; req_b3 = '0;
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_sum", int'(rsp_sum), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_add_en", int'(add_en), 0);
        chk("rst_busy3", int'(busy3), 0);
        Rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].req, tbl[i].a, tbl[i].b, tbl[i].gnt, tbl[i].sum, tbl[i].ovf, 1'b0);

        // Operands are frozen at the grant decision (pointer is 2 here).
        req = 4'b0001; req_a = 16'h0002; req_b = 16'h0002;
        @(negedge Clk);
        chk("frz_gnt", int'(gnt), 1);
        req_a = 16'h0005;
        req   = '0;
        @(negedge Clk);
        @(negedge Clk);
        chk("frz_rsp_valid", int'(rsp_valid), 1);
        chk("frz_rsp_sum", int'(rsp_sum), 4);
        @(negedge Clk);

        // Reset during WAIT discards the op and rewinds the pointer (now 1).
        req = 4'b0001; req_a = 16'h0007; req_b = 16'h0006;
        @(negedge Clk);
        chk("rstw_gnt", int'(gnt), 1);
        req = '0;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("rstw_rsp_valid", int'(rsp_valid), 0);
        chk("rstw_rsp_sum", int'(rsp_sum), 0);
        chk("rstw_busy", int'(busy), 0);
        chk("rstw_add_a", int'(add_a), 0);
        chk("rstw_gnt_off", int'(gnt), 0);
        run_op(4'b0011, 16'h0021, 16'h0013, 4'b0001, 4'd4, 1'b0, 1'b0);

        // All four requesting from reset: strict rotation, one grant every 4 cycles.
        Rst = 1'b1;
        req = 4'b1111;
        @(negedge Clk);
        Rst = 1'b0;
        run_op(4'b1111, 16'h4321, 16'h1111, 4'b0001, 4'd2, 1'b0, 1'b0);
        run_op(4'b1111, 16'h4321, 16'h1111, 4'b0010, 4'd3, 1'b0, 1'b0);
        run_op(4'b1111, 16'h4321, 16'h1111, 4'b0100, 4'd4, 1'b0, 1'b0);
        run_op(4'b1111, 16'h4321, 16'h1111, 4'b1000, 4'd5, 1'b0, 1'b0);
        run_op(4'b1111, 16'h4321, 16'h1111, 4'b0001, 4'd2, 1'b0, 1'b0);
        req = '0;

        // ADD_LAT=3: response five cycles after the request cycle.
        req3 = 4'b0001; req_a3 = 16'h000A; req_b3 = 16'h0009;
        @(negedge Clk);
        chk("l3_gnt", int'(gnt3), 1);
        chk("l3_add_en", int'(add_en3), 1);
        req3 = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("l3_rsp_early", int'(rsp_valid3), 0);
            chk("l3_add_en_off", int'(add_en3), 0);
            chk("l3_busy", int'(busy3), 1);
        end
        @(negedge Clk);
        chk("l3_rsp_valid", int'(rsp_valid3), 1);
        chk("l3_rsp_sum", int'(rsp_sum3), 3);
        chk("l3_rsp_ovf", int'(rsp_ovf3), 1);
        @(negedge Clk);
        chk("l3_rsp_end", int'(rsp_valid3), 0);
        chk("l3_busy_end", int'(busy3), 0);

        // Random ops against a transaction-level round-robin model.
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        ptr = 0;
        for (int n = 0; n < 150; n++) begin
            r  = ($urandom_range(4) == 0) ? 4'b0000 : 4'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            eg = '0;
            s  = '0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (ptr + k) % 4;
                if (eg == 0 && r[i]) begin
                    eg  = 4'(1 << i);
                    s   = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]};
                    ptr = (i + 1) % 4;
                end
            end
            run_op(r, a, b, eg, s[3:0], s[4], 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
